// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word RAM.
// Each access takes IDLE -> ACCESS -> RESP, so back-to-back accesses complete every 3 cycles.
// Accesses outside the RAM write nothing and read back 0.
//
//   state  | meaning
//   IDLE   | waiting for a request; the arbitration winner is latched on exit
//   ACCESS | RAM address/data/enables driven from the latched request
//   RESP   | registered RAM data returned; ready pulses on the granted port
module mem_port_arbiter #(
    parameter int WORDS = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_valid,
    input  logic [31:0]   p0_addr,
    input  logic [31:0]   p0_wdata,
    input  logic [3:0]    p0_wstrb,
    output logic          p0_ready,
    output logic [31:0]   p0_rdata,
    input  logic          p1_valid,
    input  logic [31:0]   p1_addr,
    input  logic [31:0]   p1_wdata,
    input  logic [3:0]    p1_wstrb,
    output logic          p1_ready,
    output logic [31:0]   p1_rdata,
    output logic [3:0]    ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata,
    output logic          busy,
    output logic          oob_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] WORDS_U = 32'(WORDS);

    state_t          state, state_nxt;
    logic            last_grant;
    logic            gnt_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      wstrb_q;
    logic            oob_q;

    logic            any_valid;
    logic            sel;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic [3:0]      sel_wstrb;
    logic            sel_oob;
    // Byte-offset bits of the address are deliberately ignored (word RAM).
    logic            addr_lsb_unused;

    // Round-robin pick: a tie goes to the port that was not served last.
    always_comb begin
        any_valid = p0_valid | p1_valid;
        sel       = (p0_valid && p1_valid) ? ~last_grant : p1_valid;
        sel_addr  = sel ? p1_addr  : p0_addr;
        sel_wdata = sel ? p1_wdata : p0_wdata;
        sel_wstrb = sel ? p1_wstrb : p0_wstrb;
        sel_oob   = (sel_addr[31:AW+2] != '0) ||
                    ({{(32-AW){1'b0}}, sel_addr[AW+1:2]} >= WORDS_U);
        addr_lsb_unused = ^sel_addr[1:0];
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: fixed three-step sequence once a request is seen.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latch the winning request on leaving IDLE; record who was served during ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            gnt_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            oob_q      <= 1'b0;
        end else begin
            if (state == IDLE && any_valid) begin
                gnt_q   <= sel;
                addr_q  <= sel_addr[AW+1:2];
                wdata_q <= sel_wdata;
                wstrb_q <= sel_wstrb;
                oob_q   <= sel_oob;
            end
            if (state == ACCESS) last_grant <= gnt_q;
        end
    end

    // Outputs decode from state so an async reset kills a pending write at once.
    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_wen   = 4'b0;
        busy      = (state != IDLE);
        p0_ready  = 1'b0;
        p1_ready  = 1'b0;
        p0_rdata  = '0;
        p1_rdata  = '0;
        oob_err   = 1'b0;
        case (state)
            ACCESS: if (!oob_q) ram_wen = wstrb_q;
            RESP: begin
                oob_err = oob_q;
                if (gnt_q) begin
                    p1_ready = 1'b1;
                    p1_rdata = oob_q ? '0 : ram_rdata;
                end else begin
                    p0_ready = 1'b1;
                    p0_rdata = oob_q ? '0 : ram_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized two-port traffic,
// compared against a word-array memory model with round-robin service ordering.
module tb_mem_port_arbiter;

    localparam int WORDS = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_valid, p1_valid;
    logic [31:0]   p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [3:0]    p0_wstrb, p1_wstrb;
    logic          p0_ready, p1_ready;
    logic [31:0]   p0_rdata, p1_rdata;
    logic [3:0]    ram_wen;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;
    logic          busy, oob_err;

    int n_tests = 0;
    int n_fail  = 0;

    // RAM attached to the arbiter (registered read, read-old-data on write)
    logic [31:0] ram [0:(1<<AW)-1] = '{default: 32'h0};
    // Reference model state
    logic [31:0] ref_mem [0:WORDS-1];
    bit          m_last;

    mem_port_arbiter #(.WORDS(WORDS), .AW(AW)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
        .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
        .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .busy(busy), .oob_err(oob_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_rdata <= ram[ram_addr];
        for (int b = 0; b < 4; b++)
            if (ram_wen[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_oob(input logic [31:0] a);
        return (a >> 2) >= 32'(WORDS);
    endfunction

    // Issue requests on either/both ports and follow them to completion.
    task automatic run_acc(input bit v0, input logic [31:0] a0, input logic [31:0] d0,
                           input logic [3:0] s0, input bit v1, input logic [31:0] a1,
                           input logic [31:0] d1, input logic [3:0] s1);
        bit          pend [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [3:0]  s [2];
        int          cyc, k, nxt, w;
        bit          oob;
        logic [31:0] exp_rd;
        pend[0] = v0; pend[1] = v1;
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; s[0] = s0; s[1] = s1;
        @(negedge clk);
        p0_valid = v0; p0_addr = a0; p0_wdata = d0; p0_wstrb = s0;
        p1_valid = v1; p1_addr = a1; p1_wdata = d1; p1_wstrb = s1;
        cyc = 0; k = 0;
        while ((pend[0] || pend[1]) && cyc < 12) begin
            @(negedge clk);
            cyc++;
            nxt = (pend[0] && pend[1]) ? int'(!m_last) : (pend[1] ? 1 : 0);
            oob = is_oob(a[nxt]);
            w   = oob ? 0 : int'(a[nxt] >> 2);
            if (cyc == 3*k + 1) begin
                chk("acc_busy", busy, 1);
                chk("acc_wen", ram_wen, oob ? 4'h0 : s[nxt]);
                chk("acc_addr", ram_addr, (a[nxt] >> 2) % (1 << AW));
                chk("acc_wdata", ram_wdata, d[nxt]);
                chk("acc_rdy", {p0_ready, p1_ready}, 0);
            end else if (cyc == 3*k + 2) begin
                exp_rd = oob ? 32'h0 : ref_mem[w];
                chk("rsp_p0_ready", p0_ready, nxt == 0);
                chk("rsp_p1_ready", p1_ready, nxt == 1);
                chk("rsp_rdata", nxt == 0 ? p0_rdata : p1_rdata, exp_rd);
                chk("rsp_other_rdata", nxt == 0 ? p1_rdata : p0_rdata, 0);
                chk("rsp_oob_err", oob_err, oob);
                chk("rsp_wen", ram_wen, 0);
                if (!oob)
                    for (int b = 0; b < 4; b++)
                        if (s[nxt][b]) ref_mem[w][8*b +: 8] = d[nxt][8*b +: 8];
                m_last    = nxt[0];
                pend[nxt] = 1'b0;
                if (nxt == 0) p0_valid = 1'b0;
                else          p1_valid = 1'b0;
                k++;
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_rdy", {p0_ready, p1_ready, oob_err}, 0);
            end
        end
        n_tests++;
        assert (!(pend[0] || pend[1])) else begin
            n_fail++;
            $error("FAIL timeout: pending %0d%0d after %0d cycles, required none", pend[1], pend[0], cyc);
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 9) == 0) return $urandom;
        return ($urandom_range(0, WORDS + 3) << 2) | $urandom_range(0, 3);
    endfunction

    initial begin
        bit v0, v1;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = 32'h0;
        reset = 1'b1;
        p0_valid = 0; p0_addr = 0; p0_wdata = 0; p0_wstrb = 0;
        p1_valid = 0; p1_addr = 0; p1_wdata = 0; p1_wstrb = 0;
        m_last = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", {p0_ready, p1_ready}, 0);
        chk("rst_p0_rdata", p0_rdata, 0);
        chk("rst_p1_rdata", p1_rdata, 0);
        chk("rst_wen", ram_wen, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_oob", oob_err, 0);
        reset = 1'b0;

        // Tie from reset: P0 first, then P1; second tie alternates.
        run_acc(1, 32'h10, 32'h0, 4'h0, 1, 32'h0C, 32'hA5A5_1234, 4'hF);
        run_acc(1, 32'h0C, 32'h0, 4'h0, 1, 32'h10, 32'h1111_2222, 4'hF);
        // Full write, read back, byte write, read back.
        run_acc(1, 32'h08, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0);
        run_acc(1, 32'h08, 32'h0, 4'h0, 0, 0, 0, 0);
        run_acc(1, 32'h08, 32'h0000_AA00, 4'h2, 0, 0, 0, 0);
        run_acc(1, 32'h08, 32'h0, 4'h0, 0, 0, 0, 0);
        chk("byte_merge", ref_mem[2], 32'hDEAD_AAEF);
        // Out-of-range write and read on P1.
        run_acc(0, 0, 0, 0, 1, 32'h80, 32'hFFFF_FFFF, 4'hF);
        run_acc(0, 0, 0, 0, 1, 32'h80, 32'h0, 4'h0);

        // Reset during the ACCESS cycle of a write must not commit it.
        @(negedge clk);
        p0_valid = 1; p0_addr = 32'h0C; p0_wdata = 32'h5555_5555; p0_wstrb = 4'hF;
        @(negedge clk);
        chk("mid_pre_wen", ram_wen, 4'hF);
        reset = 1'b1;
        #1;
        chk("mid_wen", ram_wen, 0);
        chk("mid_busy", busy, 0);
        chk("mid_addr", ram_addr, 0);
        chk("mid_wdata", ram_wdata, 0);
        chk("mid_rdy", {p0_ready, p1_ready, oob_err}, 0);
        p0_valid = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
        m_last = 1'b1;
        run_acc(1, 32'h0C, 32'h0, 4'h0, 0, 0, 0, 0);
        chk("mid_keep", ref_mem[3], 32'hA5A5_1234);

        // Randomized traffic.
        for (int it = 0; it < 40; it++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_acc(v0, rnd_addr(), $urandom, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)),
                    v1, rnd_addr(), $urandom, $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(0, 15)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
